// File: rtl/tqvp_dlmiles_i2c_errmon.sv
// I2C error monitor / sequencer.
// Watches the bus while the I2C engine is busy and reports the first fault
// of a transaction as a single-cycle strobe on stb_error_o. The strobe bits
// are {TIMEOUT, IO, GENERIC}. While a fault is held it asserts abort_o to the
// engine until software acknowledges it. The monitor then waits for the
// transaction to drain before it can arm again.
//
// Ports:
//   clk, rst_n     project clock, asynchronous active-low reset
//   cfg_timeout_i  SCL-stuck timeout in prescaled ticks; 0 disables it
//   busy_i         engine transaction in progress
//   scl_i, sda_i   synchronised bus levels
//   sda_rel_i      engine has released SDA and expects it to read high
//   nack_i         1-cycle NACK pulse
//   clear_i        1-cycle fault acknowledge (status register write)
//   stb_error_o    1-cycle error strobe with at most one bit set
//   abort_o        abort request, high while in FAULT
//   state_o        IDLE=0, ARMED=1, FAULT=2, RECOVER=3
module tqvp_dlmiles_i2c_errmon #(
  parameter int unsigned PRESCALE  = 64,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
  input  logic                 busy_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  input  logic                 sda_rel_i,
  input  logic                 nack_i,
  input  logic                 clear_i,
  output logic [2:0]           stb_error_o,
  output logic                 abort_o,
  output logic [1:0]           state_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StFault   = 2'd2,
    StRecover = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;
  logic [2:0]            stb_q, stb_d;
  logic                  abort_q;
  logic                  scl_q;

  logic scl_edge, scl_rise, armed, tick;
  logic det_timeout, det_io, det_generic;

  assign scl_edge = scl_i ^ scl_q;
  assign scl_rise = scl_i & ~scl_q;
  assign armed    = (state_q == StArmed);
  assign tick     = (pcnt_q == PLast);

  // cfg_timeout_i is compared live, so lowering it below tcnt fires at once.
  assign det_timeout = armed && (cfg_timeout_i != '0) && (tcnt_q >= cfg_timeout_i);
  assign det_io      = armed && scl_rise && sda_rel_i && !sda_i;
  assign det_generic = armed && nack_i;

  // Counters only run in ARMED; holding them at zero elsewhere gives the
  // required clear-on-entry without tracking the entry transition.
  always_comb begin
    pcnt_d = '0;
    tcnt_d = '0;
    if (armed && !scl_edge) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      tcnt_d = tcnt_q;
      if (tick && (tcnt_q != '1)) begin
        tcnt_d = tcnt_q + TIMEOUT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = 3'b000;
    case (state_q)
      StIdle: begin
        if (busy_i) state_d = StArmed;
      end
      StArmed: begin
        // Detection takes priority over the transaction ending.
        if (det_timeout) begin
          stb_d   = 3'b100;
          state_d = StFault;
        end else if (det_io) begin
          stb_d   = 3'b010;
          state_d = StFault;
        end else if (det_generic) begin
          stb_d   = 3'b001;
          state_d = StFault;
        end else if (!busy_i) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (clear_i) state_d = busy_i ? StRecover : StIdle;
      end
      StRecover: begin
        if (!busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      stb_q   <= 3'b000;
      abort_q <= 1'b0;
      scl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      stb_q   <= stb_d;
      abort_q <= (state_d == StFault);
      scl_q   <= scl_i;
    end
  end

  assign stb_error_o = stb_q;
  assign abort_o     = abort_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_errmon.sv
module tb_tqvp_dlmiles_i2c_errmon;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_timeout_i;
  logic       busy_i, scl_i, sda_i, sda_rel_i, nack_i, clear_i;
  logic [2:0] stb_error_o;
  logic       abort_o;
  logic [1:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  // Expected {stb, abort, state}, pushed when a step is driven.
  logic [5:0] exp_q[$];

  typedef struct {
    logic       busy, scl, sda, rel, nack, clr;
    logic [7:0] cfg;
    logic [5:0] exp;
  } stim_t;

  tqvp_dlmiles_i2c_errmon #(
    .PRESCALE (4),
    .TIMEOUT_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_timeout_i(cfg_timeout_i),
    .busy_i       (busy_i),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .sda_rel_i    (sda_rel_i),
    .nack_i       (nack_i),
    .clear_i      (clear_i),
    .stb_error_o  (stb_error_o),
    .abort_o      (abort_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pk(input logic [2:0] stb, input logic ab, input logic [1:0] st);
    return {stb, ab, st};
  endfunction

  function automatic stim_t mk(input logic busy, input logic scl, input logic sda, input logic rel,
                               input logic nack, input logic clr, input logic [7:0] cfg,
                               input logic [5:0] exp);
    stim_t s;
    s.busy = busy; s.scl = scl; s.sda = sda; s.rel = rel;
    s.nack = nack; s.clr = clr; s.cfg = cfg; s.exp = exp;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    busy_i = s.busy; scl_i = s.scl; sda_i = s.sda; sda_rel_i = s.rel;
    nack_i = s.nack; clear_i = s.clr; cfg_timeout_i = s.cfg;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [5:0] e;
    rst_n = 1'b0;
    busy_i = 0; scl_i = 0; sda_i = 1; sda_rel_i = 0; nack_i = 0; clear_i = 0;
    cfg_timeout_i = 8'd0;
    exp_q.push_back(pk(3'b000, 1'b0, 2'd0));
    #3;
    e = exp_q.pop_front();
    vectors++;
    if ({stb_error_o, abort_o, state_o} !== e) begin
      miscompares++;
      $display("FAIL reset_assert: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
               stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(pk(3'b000, 1'b0, 2'd0));
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({stb_error_o, abort_o, state_o} !== e) begin
      miscompares++;
      $display("FAIL reset_release: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
               stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
    end
  endtask

  // SCL held low: tick every 4 clk, tcnt reaches 3 after 12 clk, strobe on the 13th.
  task automatic test_timeout();
    stim_t sq[$];
    logic [5:0] e;
    for (int i = 0; i < 15; i++) begin
      sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd3,
                      (i == 13) ? pk(3'b100, 1, 2'd2) :
                      (i == 14) ? pk(3'b000, 1, 2'd2) : pk(3'b000, 0, 2'd1)));
    end
    sq.push_back(mk(0, 0, 1, 0, 0, 1, 8'd3, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL timeout step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_scl_toggle();
    stim_t sq[$];
    logic [5:0] e;
    for (int i = 0; i < 200; i++) begin
      sq.push_back(mk(1, logic'((i / 8) % 2), 1, 0, 0, 0, 8'd3, pk(3'b000, 0, 2'd1)));
    end
    for (int i = 0; i < 100; i++) begin
      sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    end
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL scl_toggle step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_io();
    stim_t sq[$];
    logic [5:0] e;
    sq.push_back(mk(1, 0, 0, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 1, 0, 1, 0, 0, 8'd0, pk(3'b010, 1, 2'd2)));
    sq.push_back(mk(1, 1, 0, 1, 0, 0, 8'd0, pk(3'b000, 1, 2'd2)));
    sq.push_back(mk(0, 1, 0, 1, 0, 1, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(0, 0, 1, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(1, 0, 1, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 1, 1, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 1, 1, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(0, 1, 1, 1, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL io step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_priority();
    stim_t sq[$];
    logic [5:0] e;
    // NACK lands in the same cycle the timeout condition first holds.
    for (int i = 0; i < 13; i++) begin
      sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd3, pk(3'b000, 0, 2'd1)));
    end
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd3, pk(3'b100, 1, 2'd2)));
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd3, pk(3'b000, 1, 2'd2)));
    sq.push_back(mk(0, 0, 1, 0, 0, 1, 8'd0, pk(3'b000, 0, 2'd0)));
    // NACK alone, a second NACK in FAULT is swallowed, NACK in IDLE ignored.
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd0, pk(3'b001, 1, 2'd2)));
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd0, pk(3'b000, 1, 2'd2)));
    sq.push_back(mk(0, 0, 1, 0, 0, 1, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(0, 0, 1, 0, 1, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL priority step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_recover();
    stim_t sq[$];
    logic [5:0] e;
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd0, pk(3'b001, 1, 2'd2)));
    sq.push_back(mk(1, 0, 1, 0, 0, 1, 8'd0, pk(3'b000, 0, 2'd3)));
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd0, pk(3'b000, 0, 2'd3)));
    sq.push_back(mk(1, 0, 1, 0, 0, 1, 8'd0, pk(3'b000, 0, 2'd3)));
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 0, 1, 0, 0, 1, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL recover step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t sq[$];
    logic [5:0] e;
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(1, 0, 1, 0, 1, 0, 8'd0, pk(3'b001, 1, 2'd2)));
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 1, 2'd2)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL async_reset_pre step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
    // Mid-cycle reset: outputs must clear well before the next clock edge.
    #2;
    rst_n = 1'b0;
    exp_q.push_back(pk(3'b000, 0, 2'd0));
    #1;
    e = exp_q.pop_front();
    vectors++;
    if ({stb_error_o, abort_o, state_o} !== e) begin
      miscompares++;
      $display("FAIL async_reset_mid: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
               stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
    end
    busy_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sq.delete();
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    sq.push_back(mk(1, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd1)));
    sq.push_back(mk(0, 0, 1, 0, 0, 0, 8'd0, pk(3'b000, 0, 2'd0)));
    foreach (sq[i]) begin
      apply(sq[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({stb_error_o, abort_o, state_o} !== e) begin
        miscompares++;
        $display("FAIL async_reset_post step %0d: got stb=%b abort=%b state=%0d want stb=%b abort=%b state=%0d",
                 i, stb_error_o, abort_o, state_o, e[5:3], e[2], e[1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_scl_toggle();
    test_io();
    test_priority();
    test_recover();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
